// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-unit constants, counter encodings and BTB entry type
package cpu_pkg;

   localparam int WIDTH_DEF  = 32;
   localparam int INSTR_STEP = 4;

   typedef enum logic [1:0] {
      CTR_SNT = 2'd0,
      CTR_WNT = 2'd1,
      CTR_WT  = 2'd2,
      CTR_ST  = 2'd3
   } ctr_e;

   // Tag and target widths follow the module parameter, so they live beside this in btb_dm.
   typedef struct packed {
      logic valid;
      ctr_e ctr;
   } btb_meta_t;

   function automatic ctr_e ctr_train(ctr_e c, logic taken);
      unique case (c)
         CTR_SNT: return taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: return taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  return taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  return taken ? CTR_ST  : CTR_WT;
         default: return c;
      endcase
   endfunction

endpackage

// File: rtl/btb_dm.sv
// rtl/btb_dm.sv - direct-mapped branch target buffer with 2-bit saturating counters
module btb_dm
   import cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] lkp_pc_i,
   output logic             pred_taken_o,
   output logic [WIDTH-1:0] pred_target_o,
   input  logic             upd_valid_i,
   input  logic [WIDTH-1:0] upd_pc_i,
   input  logic [WIDTH-1:0] upd_target_i,
   input  logic             upd_taken_i
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int TAG_W = WIDTH - IDX_W - 2;

   btb_meta_t        meta_q [DEPTH];
   logic [TAG_W-1:0] tag_q  [DEPTH];
   logic [WIDTH-1:0] tgt_q  [DEPTH];

   logic [IDX_W-1:0] lkp_idx, upd_idx;
   logic [TAG_W-1:0] lkp_tag, upd_tag;
   logic             lkp_hit, upd_hit, upd_we;
   btb_meta_t        meta_d;
   logic [TAG_W-1:0] tag_d;
   logic [WIDTH-1:0] tgt_d;
   logic             unused_pc_lsbs;

   assign lkp_idx = lkp_pc_i[IDX_W+1:2];
   assign lkp_tag = lkp_pc_i[WIDTH-1:IDX_W+2];
   assign upd_idx = upd_pc_i[IDX_W+1:2];
   assign upd_tag = upd_pc_i[WIDTH-1:IDX_W+2];
   assign unused_pc_lsbs = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};

   // Reads see the registered array, so a same-cycle update is not yet visible.
   assign lkp_hit       = meta_q[lkp_idx].valid && (tag_q[lkp_idx] == lkp_tag);
   assign pred_taken_o  = lkp_hit && meta_q[lkp_idx].ctr[1];
   assign pred_target_o = pred_taken_o ? tgt_q[lkp_idx] : '0;

   assign upd_hit = meta_q[upd_idx].valid && (tag_q[upd_idx] == upd_tag);

   always_comb begin
      upd_we = 1'b0;
      meta_d = meta_q[upd_idx];
      tag_d  = tag_q[upd_idx];
      tgt_d  = tgt_q[upd_idx];
      if (en_i && upd_valid_i) begin
         if (upd_hit) begin
            upd_we     = 1'b1;
            meta_d.ctr = ctr_train(meta_q[upd_idx].ctr, upd_taken_i);
            if (upd_taken_i) tgt_d = upd_target_i;
         end else if (upd_taken_i) begin
            upd_we = 1'b1;
            meta_d = '{valid: 1'b1, ctr: CTR_WT};
            tag_d  = upd_tag;
            tgt_d  = upd_target_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            meta_q[i] <= '{valid: 1'b0, ctr: CTR_SNT};
            tag_q[i]  <= '0;
            tgt_q[i]  <= '0;
         end
      end else if (upd_we) begin
         meta_q[upd_idx] <= meta_d;
         tag_q[upd_idx]  <= tag_d;
         tgt_q[upd_idx]  <= tgt_d;
      end
   end

endmodule

// File: rtl/pc_predict_unit.sv
// rtl/pc_predict_unit.sv - fetch PC register with redirect, stall and BTB-predicted next PC
module pc_predict_unit
   import cpu_pkg::*;
#(
   parameter int               WIDTH    = WIDTH_DEF,
   parameter int               DEPTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             redirect_i,
   input  logic [WIDTH-1:0] redirect_pc_i,
   input  logic             upd_valid_i,
   input  logic [WIDTH-1:0] upd_pc_i,
   input  logic [WIDTH-1:0] upd_target_i,
   input  logic             upd_taken_i,
   output logic [WIDTH-1:0] pc_o,
   output logic             pred_taken_o,
   output logic [WIDTH-1:0] pred_target_o
);

   logic [WIDTH-1:0] pc_q, pc_d;

   btb_dm #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_btb (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en_i         (start_i),
      .lkp_pc_i     (pc_q),
      .pred_taken_o (pred_taken_o),
      .pred_target_o(pred_target_o),
      .upd_valid_i  (upd_valid_i),
      .upd_pc_i     (upd_pc_i),
      .upd_target_i (upd_target_i),
      .upd_taken_i  (upd_taken_i)
   );

   // Redirect outranks stall: an EX correction must land even while IF is frozen.
   always_comb begin
      pc_d = pc_q;
      if (start_i) begin
         if (redirect_i)        pc_d = redirect_pc_i;
         else if (stall_i)      pc_d = pc_q;
         else if (pred_taken_o) pc_d = pred_target_o;
         else                   pc_d = pc_q + WIDTH'(INSTR_STEP);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb/tb_pc_predict_unit.sv - directed and randomized self-checking bench for pc_predict_unit
module tb_pc_predict_unit;

   localparam int          D   = 16;
   localparam int          IW  = 4;
   localparam logic [31:0] RPC = 32'h100;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0, start_i = 1'b0, stall_i = 1'b0, redirect_i = 1'b0;
   logic        upd_valid_i = 1'b0, upd_taken_i = 1'b0;
   logic [31:0] redirect_pc_i = '0, upd_pc_i = '0, upd_target_i = '0;
   logic [31:0] pc_o, pred_target_o;
   logic        pred_taken_o;

   int checks = 0;
   int failures = 0;

   bit          mv   [D];
   logic [31:0] mtag [D];
   logic [31:0] mtgt [D];
   int          mctr [D];
   logic [31:0] mpc;

   pc_predict_unit #(.WIDTH(32), .DEPTH(D), .RESET_PC(RPC)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
      .upd_taken_i(upd_taken_i), .pc_o(pc_o), .pred_taken_o(pred_taken_o),
      .pred_target_o(pred_target_o)
   );

   always #5 clk = ~clk;

   function automatic int midx(logic [31:0] pc);
      return int'((pc >> 2) % 32'(D));
   endfunction

   function automatic logic [31:0] mtagof(logic [31:0] pc);
      return pc >> (2 + IW);
   endfunction

   task automatic model_reset();
      mpc = RPC;
      for (int i = 0; i < D; i++) begin
         mv[i] = 0; mtag[i] = '0; mtgt[i] = '0; mctr[i] = 0;
      end
   endtask

   task automatic m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
      int i;
      i  = midx(pc);
      t  = mv[i] && (mtag[i] == mtagof(pc)) && (mctr[i] >= 2);
      tg = t ? mtgt[i] : 32'h0;
   endtask

   task automatic m_update(input logic [31:0] pc, input logic [31:0] tg, input logic tk);
      int i;
      i = midx(pc);
      if (mv[i] && mtag[i] == mtagof(pc)) begin
         if (tk) begin
            mctr[i] = (mctr[i] < 3) ? mctr[i] + 1 : 3;
            mtgt[i] = tg;
         end else begin
            mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
         end
      end else if (tk) begin
         mv[i] = 1; mtag[i] = mtagof(pc); mtgt[i] = tg; mctr[i] = 2;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic expect_now(input string tag, input logic [31:0] pc, input logic pt,
                             input logic [31:0] tg);
      check({tag, "_pc"}, pc_o, pc);
      check({tag, "_taken"}, {31'b0, pred_taken_o}, {31'b0, pt});
      check({tag, "_target"}, pred_target_o, tg);
   endtask

   // One clock: drive, check against the model mid-cycle, then advance the model at the edge.
   task automatic cycle(input logic st, input logic sl, input logic rd, input logic [31:0] rpc,
                        input logic uv, input logic [31:0] upc, input logic [31:0] utg,
                        input logic utk);
      logic        pt;
      logic [31:0] ptg, npc;
      start_i = st; stall_i = sl; redirect_i = rd; redirect_pc_i = rpc;
      upd_valid_i = uv; upd_pc_i = upc; upd_target_i = utg; upd_taken_i = utk;
      @(negedge clk);
      m_lookup(mpc, pt, ptg);
      expect_now("model", mpc, pt, ptg);
      if (!st)     npc = mpc;
      else if (rd) npc = rpc;
      else if (sl) npc = mpc;
      else if (pt) npc = ptg;
      else         npc = mpc + 32'd4;
      @(posedge clk);
      #1;
      mpc = npc;
      if (st && uv) m_update(upc, utg, utk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1, 0, 0, '0, 0, '0, '0, 0);
   endtask

   task automatic goto_pc(input logic [31:0] pc);
      cycle(1, 0, 1, pc, 0, '0, '0, 0);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input logic tk);
      cycle(1, 1, 0, '0, 1, pc, tg, tk);
   endtask

   function automatic logic [31:0] rand_pc();
      return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      expect_now("reset", RPC, 0, 32'h0);
      @(negedge clk);
      rst_i = 1'b1;
      @(posedge clk);
      #1;

      idle(3);
      expect_now("seq", 32'h10C, 0, 32'h0);

      for (int k = 0; k < 3; k++) cycle(0, 0, 1, 32'h999, 1, 32'h10C, 32'h500, 1);
      expect_now("gate", 32'h10C, 0, 32'h0);

      cycle(1, 1, 1, 32'h40, 0, '0, '0, 0);
      expect_now("redir_stall", 32'h40, 0, 32'h0);

      upd(32'h10, 32'h80, 1);
      goto_pc(32'h10);
      expect_now("alloc_hit", 32'h10, 1, 32'h80);
      idle(1);
      expect_now("alloc_jump", 32'h80, 0, 32'h0);

      upd(32'h10, 32'h80, 0);
      goto_pc(32'h10);
      expect_now("hyst_wnt", 32'h10, 0, 32'h0);
      upd(32'h10, 32'h80, 1);
      upd(32'h10, 32'h80, 1);
      upd(32'h10, 32'h80, 0);
      goto_pc(32'h10);
      expect_now("hyst_wt", 32'h10, 1, 32'h80);

      upd(32'h50, 32'hA0, 1);
      goto_pc(32'h10);
      expect_now("alias_old", 32'h10, 0, 32'h0);
      goto_pc(32'h50);
      expect_now("alias_new", 32'h50, 1, 32'hA0);
      upd(32'h90, 32'h33, 0);
      goto_pc(32'h50);
      expect_now("alias_keep", 32'h50, 1, 32'hA0);

      cycle(1, 0, 1, 32'h200, 1, 32'h200, 32'h300, 1);
      expect_now("redir_upd", 32'h200, 1, 32'h300);

      goto_pc(32'hFFFF_FFFC);
      expect_now("wrap_pre", 32'hFFFF_FFFC, 0, 32'h0);
      idle(1);
      expect_now("wrap", 32'h0, 0, 32'h0);

      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 6) == 0), rand_pc(),
               ($urandom_range(0, 9) < 4), rand_pc(), rand_pc(), $urandom_range(0, 1) == 1);
      end

      upd(32'h50, 32'hA0, 1);
      upd(32'h50, 32'hA0, 1);
      redirect_i = 1'b1; redirect_pc_i = 32'h777;
      upd_valid_i = 1'b1; upd_pc_i = 32'h10; upd_target_i = 32'h88; upd_taken_i = 1'b1;
      #2;
      rst_i = 1'b0;
      #1;
      model_reset();
      expect_now("rst_async", RPC, 0, 32'h0);
      @(posedge clk);
      #1;
      expect_now("rst_hold", RPC, 0, 32'h0);
      @(negedge clk);
      start_i = 1'b0; redirect_i = 1'b0; upd_valid_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      goto_pc(32'h50);
      expect_now("rst_miss50", 32'h50, 0, 32'h0);
      goto_pc(32'h10);
      expect_now("rst_miss10", 32'h10, 0, 32'h0);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised program-counter unit for the pipelined CPU, replacing the plain PC register at the head of IF. It holds the fetch PC and selects the next PC from four sources: hold, EX-stage redirect, BTB-predicted target, or sequential increment. It contains a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, trained by resolved branches from EX.

## Interface
- WIDTH, 32, PC and target width; must be at least IDX_W+3.
- DEPTH, 16, number of BTB entries; power of two, at least 2; IDX_W = log2(DEPTH).
- RESET_PC, 0, value loaded into pc_o on reset.

Ports (direction, width, meaning):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  run enable; while 0, all state holds.
- stall_i  in  1  hazard hold; 1 freezes pc_o.
- redirect_i  in  1  EX mispredict/jump correction.
- redirect_pc_i  in  WIDTH  corrected PC.
- upd_valid_i  in  1  resolved-branch update strobe.
- upd_pc_i  in  WIDTH  PC of the resolved branch.
- upd_target_i  in  WIDTH  resolved branch target.
- upd_taken_i  in  1  resolved branch direction.
- pc_o  out  WIDTH  current fetch PC.
- pred_taken_o  out  1  BTB predicts taken for pc_o.
- pred_target_o  out  WIDTH  predicted target for pc_o; 0 when pred_taken_o is 0.

## Operation
- BTB addressing: index = pc[IDX_W+1:2]; tag = pc[WIDTH-1:IDX_W+2]; bits [1:0] are ignored.
- Each entry holds valid, tag, target, and ctr[1:0].
- Lookup hit: entry valid and tag equal. pred_taken_o = hit & ctr[1].
- Next-PC priority, evaluated each rising edge:
  1. start_i = 0: hold pc_o and the BTB.
  2. redirect_i = 1: load redirect_pc_i. Redirect overrides stall_i.
  3. stall_i = 1: hold pc_o.
  4. pred_taken_o = 1: load pred_target_o.
  5. Otherwise: load pc_o + 4, wrapping modulo 2^WIDTH.
- BTB update on upd_valid_i & start_i. stall_i does not affect updates.
  - Hit on upd_pc_i: taken increments ctr (saturating at 3); not-taken decrements ctr (saturating at 0). Taken also rewrites the target.
  - Miss and taken: allocate (or overwrite) the entry with valid=1, new tag, target, ctr=2'b10.
  - Miss and not-taken: no change.
- Reset: pc_o = RESET_PC; all valid bits cleared; ctr and target cleared.
- Reset asserted mid-operation discards any pending redirect or update.

## Timing
- pc_o is registered. pred_taken_o and pred_target_o are combinational from pc_o and BTB state, in the same cycle.
- Redirect latency: pc_o shows redirect_pc_i one cycle after redirect_i is sampled.
- Update latency: a BTB write is visible to lookups one cycle after upd_valid_i. A same-cycle lookup of the same index sees the old contents.
- Simultaneous redirect and update: both take effect. The next lookup, at the redirected PC, sees the updated entry.
- Reset is asynchronous on assertion and synchronous-safe on release: the first update occurs at the first edge after rst_i rises with start_i = 1.

## Structure
- Shared package (cpu_pkg): WIDTH default, instruction step constant 4, ctr encodings (SNT=0, WNT=1, WT=2, ST=3), and the BTB entry typedef.
- One natural sub-module, btb_dm: entry storage with combinational read and synchronous write/update logic.
- pc_predict_unit holds the PC register and the next-PC mux.

## Test plan
- Reset and sequential fetch: reset with RESET_PC=0x100, start_i=1 -> pc_o steps 0x100, 0x104, 0x108; pred_taken_o=0.
- Gating: start_i=0 for 3 cycles -> pc_o frozen. Then stall_i=1 with redirect_i=1, redirect_pc_i=0x40 -> pc_o=0x40 on the next cycle.
- Allocate and predict: update upd_pc=0x10, target=0x80, taken -> when pc_o reaches 0x10, pred_taken_o=1 and pred_target_o=0x80; next pc_o=0x80.
- Counter hysteresis: with the entry at WT, one not-taken update leaves ctr=WNT -> no prediction at 0x10. Two taken updates -> ST. One not-taken -> WT, still predicted taken.
- Aliasing (DEPTH=16): allocate 0x10, then a taken update at 0x50 (same index, different tag) -> 0x10 misses and 0x50 hits. A not-taken update at 0x90 (miss) leaves 0x50 intact.
- Wrap and reset: pc_o=0xFFFFFFFC with no hit -> next pc_o=0x0. Assert rst_i low mid-run -> pc_o=RESET_PC immediately and all prior BTB entries miss.
